// File: rtl/fifo_pkg.sv
// Shared defaults and lane helpers for the FIFO word packer.
package fifo_pkg;

  localparam int DEF_DWIDTH = 4;
  localparam int DEF_RATIO  = 4;

  function automatic int lane_sel(input int cnt, input int dw);
    return cnt * dw;
  endfunction

endpackage

// File: rtl/fifo_out_slice.sv
// One-entry valid/ready holding register for packed output words.
module fifo_out_slice #(
  parameter int OWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [OWIDTH-1:0] load_data,
  input  logic              out_ready,
  output logic              out_free,
  output logic              out_valid,
  output logic [OWIDTH-1:0] out_data
);

  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Drains a registered-read FIFO and packs RATIO entries LSB-first per word.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int RATIO  = DEF_RATIO,
  localparam int OWIDTH = DWIDTH * RATIO
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DWIDTH-1:0] fifo_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OWIDTH-1:0] out_data,
  output logic              busy
);

  localparam int CW = $clog2(RATIO + 1);

  logic [CW-1:0]     cnt;
  logic              pending;
  logic [OWIDTH-1:0] pack;
  logic [OWIDTH-1:0] pack_cur;
  logic [CW:0]       fill;
  logic              word_done;
  logic              out_free;
  logic              load;

  // Count the in-flight read so we never pop more entries than lanes left.
  assign fill = {1'b0, cnt} + (CW+1)'(pending);

  assign fifo_rd_en = !rst && !fifo_empty && !flush
                    && (fill < (CW+1)'(RATIO));

  always_comb begin
    pack_cur = pack;
    for (int i = 0; i < RATIO; i++) begin
      if (pending && cnt == CW'(i))
        pack_cur[lane_sel(i, DWIDTH) +: DWIDTH] = fifo_data;
    end
  end

  assign word_done = (pending && cnt == CW'(RATIO - 1))
                   || cnt == CW'(RATIO);
  assign load = word_done && out_free && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      pending <= 1'b0;
      pack    <= '0;
    end else begin
      pending <= fifo_rd_en;
      if (flush || load) begin
        cnt  <= '0;
        pack <= '0;
      end else if (pending) begin
        cnt  <= cnt + CW'(1);
        pack <= pack_cur;
      end
    end
  end

  fifo_out_slice #(
    .OWIDTH(OWIDTH)
  ) u_slice (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_data(pack_cur),
    .out_ready(out_ready),
    .out_free (out_free),
    .out_valid(out_valid),
    .out_data (out_data)
  );

  assign busy = (cnt != '0) || pending || out_valid;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench: behavioural FIFO in front of the packer, random streaming.
module tb_fifo_word_packer;

  localparam int DW = 4;
  localparam int R = 4;
  localparam int OW = DW * R;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  logic fifo_empty;
  logic fifo_rd_en;
  logic [DW-1:0] fifo_data;
  logic flush;
  logic out_valid;
  logic out_ready;
  logic [OW-1:0] out_data;
  logic busy;

  always #5 clk = ~clk;

  fifo_word_packer #(
    .DWIDTH(DW),
    .RATIO (R)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_data (fifo_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Behavioural FIFO, AWIDTH=4, registered read.
  logic wr_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] mem [DEPTH];
  logic [3:0] wp, rp;
  logic [4:0] fcount;
  logic fpush, fpop;

  assign fifo_empty = (fcount == 5'd0);
  assign fpush = wr_en && (fcount < 5'(DEPTH));
  assign fpop = fifo_rd_en && !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      fcount <= '0;
      fifo_data <= '0;
    end else begin
      if (fpush) begin
        mem[wp] <= wr_data;
        wp <= wp + 4'd1;
      end
      if (fpop) begin
        fifo_data <= mem[rp];
        rp <= rp + 4'd1;
      end
      fcount <= fcount + 5'(fpush) - 5'(fpop);
    end
  end

  // Reference model: group written entries in fours, LSB-first.
  logic [OW-1:0] exp_q [$];
  logic [DW-1:0] part [$];
  int compared = 0;
  int mismatched = 0;
  int vcount = 0;
  int words_rx = 0;

  function automatic void push_entry(input logic [DW-1:0] d);
    logic [OW-1:0] w;
    part.push_back(d);
    if (part.size() == R) begin
      w = '0;
      for (int i = 0; i < R; i++)
        w = w | (OW'(part[i]) << (i * DW));
      exp_q.push_back(w);
      part.delete();
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic put(input logic [DW-1:0] d);
    wr_en = 1'b1;
    wr_data = d;
    push_entry(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d words missing", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_state(input logic [2:0] c, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dut.cnt == c && dut.pending) && n < 40);
    if (!(dut.cnt == c && dut.pending)) begin
      compared++;
      mismatched++;
      $display("FAIL %s: state cnt=%0d pending=1 never seen", name, c);
    end
  endtask

  // Monitor: scoreboard pop on handshake, hold stability, no pop on empty.
  logic hold_prev = 1'b0;
  logic [OW-1:0] prev_data;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (fifo_empty) begin
        compared++;
        if (fifo_rd_en) begin
          mismatched++;
          $display("FAIL rd_on_empty: got rd_en=1 want 0");
        end
      end
      if (hold_prev) begin
        compared++;
        if (!out_valid || out_data !== prev_data) begin
          mismatched++;
          $display("FAIL hold: got v=%0b d=%0h want v=1 d=%0h",
                   out_valid, out_data, prev_data);
        end
      end
      if (out_valid && out_ready) begin
        compared++;
        words_rx++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL word: got %0h want none", out_data);
        end else begin
          logic [OW-1:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            mismatched++;
            $display("FAIL word: got %0h want %0h", out_data, e);
          end
        end
      end
      if (out_valid) vcount++;
      hold_prev = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  initial begin
    int written;
    int base;
    rst = 1'b1;
    wr_en = 1'b0;
    wr_data = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycles(1);

    // 1: single word
    out_ready = 1'b1;
    vcount = 0;
    for (int i = 1; i <= 4; i++) put(4'(i));
    drain(40);
    cycles(3);
    chk("t1_valid_cycles", 32'(vcount), 1);

    // 2: backpressure, second word held
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) put(4'(i));
    cycles(15);
    chk("t2_valid", 32'(out_valid), 1);
    chk("t2_data", 32'(out_data), 32'h3210);
    chk("t2_cnt", 32'(dut.cnt), 4);
    chk("t2_rd_en", 32'(fifo_rd_en), 0);
    chk("t2_empty", 32'(fifo_empty), 1);
    out_ready = 1'b1;
    cycles(1);
    chk("t2_next_valid", 32'(out_valid), 1);
    chk("t2_next_data", 32'(out_data), 32'h7654);
    drain(10);

    // 3: empty mid-word
    put(4'h1);
    put(4'h2);
    vcount = 0;
    cycles(20);
    chk("t3_no_valid", 32'(vcount), 0);
    chk("t3_busy", 32'(busy), 1);
    put(4'h3);
    put(4'h4);
    drain(20);

    // 4: flush on capture of B
    put(4'hA);
    put(4'hB);
    wait_state(3'd1, "t4_sync");
    flush = 1'b1;
    part.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
    vcount = 0;
    cycles(4);
    chk("t4_no_valid", 32'(vcount), 0);
    chk("t4_busy", 32'(busy), 0);
    for (int i = 1; i <= 4; i++) put(4'(i));
    drain(20);
    cycles(2);

    // 5: async reset mid-word with read in flight
    put(4'h1);
    put(4'h2);
    put(4'h3);
    wait_state(3'd2, "t5_sync");
    rst = 1'b1;
    #1;
    chk("t5_rd_en", 32'(fifo_rd_en), 0);
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_data", 32'(out_data), 0);
    chk("t5_busy", 32'(busy), 0);
    part.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycles(1);
    for (int i = 5; i <= 8; i++) put(4'(i));
    drain(20);

    // 6: random streaming
    written = 0;
    base = words_rx;
    for (int c = 0; c < 3000; c++) begin
      if (written == 64 && exp_q.size() == 0) break;
      out_ready = 1'($urandom % 2);
      if (written < 64 && fcount < 5'(DEPTH) && ($urandom % 2) == 1) begin
        wr_en = 1'b1;
        wr_data = 4'($urandom);
        push_entry(wr_data);
        written++;
      end else begin
        wr_en = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    out_ready = 1'b1;
    drain(40);
    chk("t6_words", 32'(words_rx - base), 16);
    chk("t6_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
